// File: rtl/bcd_timer_core_pkg.sv
// bcd_timer_core_pkg: shared FSM encoding, digit width and digit radix helper
package bcd_timer_core_pkg;
  localparam int DIGIT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;
  function automatic logic [DIGIT_W-1:0] digit_radix(input int i, input int n);
    return (i == n - 1 || i % 2 == 0) ? 4'd10 : 4'd6;
  endfunction
endpackage

// File: rtl/bcd_timer_core_tick_gen.sv
// tick_gen: prescaler emitting a one-cycle tick every CLK_HZ/TICK_HZ cycles
module tick_gen #(
  parameter int CLK_HZ = 125_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  assign tick = cnt == CW'(DIV - 1);
  always_ff @(posedge clk) cnt <= (reset || restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/bcd_timer_core.sv
// bcd_timer_core: mixed-radix BCD up/down timer with lap capture and digit editing
module bcd_timer_core
  import bcd_timer_core_pkg::*;
#(
  parameter int CLK_HZ = 125_000_000,
  parameter int TICK_HZ = 1,
  parameter int N_DIGITS = 4,
  parameter logic [4*N_DIGITS-1:0] PRESET = 16'h0500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    lap,
  input  logic                    edit_next,
  input  logic                    edit_inc,
  input  logic                    edit_dec,
  input  logic                    mode_down,
  output logic [4*N_DIGITS-1:0]   digits,
  output logic [4*N_DIGITS-1:0]   lap_digits,
  output logic                    lap_valid,
  output logic [2:0]              edit_sel,
  output logic                    running,
  output logic                    expired,
  output logic                    wrap
);
  localparam int W = DIGIT_W * N_DIGITS;
  state_t state;
  logic mode_q, tick, inc_c, dec_b, mode_chg, idle_pause, start_ok;
  logic [W-1:0] inc_v, dec_v, edit_v;
  logic [DIGIT_W-1:0] d, mx;
  always_comb begin
    inc_v = digits;
    dec_v = digits;
    edit_v = digits;
    inc_c = 1'b1;
    dec_b = 1'b1;
    d = '0;
    mx = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      d = digits[DIGIT_W*i +: DIGIT_W];
      mx = digit_radix(i, N_DIGITS) - 4'd1;
      inc_v[DIGIT_W*i +: DIGIT_W] = inc_c ? (d == mx ? '0 : d + 4'd1) : d;
      dec_v[DIGIT_W*i +: DIGIT_W] = dec_b ? (d == '0 ? mx : d - 4'd1) : d;
      if (edit_sel == 3'(i))
        edit_v[DIGIT_W*i +: DIGIT_W] = edit_inc ? (d == mx ? '0 : d + 4'd1) : (d == '0 ? mx : d - 4'd1);
      inc_c = inc_c && d == mx;
      dec_b = dec_b && d == '0;
    end
  end
  assign idle_pause = state == IDLE || state == PAUSE;
  assign mode_chg = state != RUN && mode_down != mode_q;
  assign start_ok = idle_pause && start && !(mode_q && digits == '0) && !clear && !mode_chg;
  assign running = state == RUN;
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .clk(clk), .reset(reset), .restart(start_ok), .tick(tick)
  );
  // mode_q resets to up mode, so a held mode_down loads PRESET one cycle after reset
  always_ff @(posedge clk) begin
    lap_valid <= 1'b0;
    expired <= 1'b0;
    wrap <= 1'b0;
    if (reset) begin
      state <= IDLE;
      digits <= '0;
      lap_digits <= '0;
      edit_sel <= '0;
      mode_q <= 1'b0;
    end else if (clear || mode_chg) begin
      state <= IDLE;
      digits <= mode_down ? PRESET : '0;
      edit_sel <= '0;
      mode_q <= mode_down;
    end else if (state == RUN) begin
      if (lap && !stop) begin
        lap_digits <= digits;
        lap_valid <= 1'b1;
      end
      if (stop) state <= PAUSE;
      if (tick && !mode_q) begin
        digits <= inc_v;
        wrap <= inc_c;
      end
      if (tick && mode_q) begin
        digits <= dec_v;
        if (dec_v == '0) begin
          state <= EXPIRED;
          expired <= 1'b1;
        end
      end
    end else if (start_ok) begin
      state <= RUN;
    end else if (idle_pause && !start && !stop) begin
      if (edit_next) edit_sel <= edit_sel == 3'(N_DIGITS - 1) ? '0 : edit_sel + 3'd1;
      if (edit_inc ^ edit_dec) digits <= edit_v;
    end
  end
endmodule

// File: tb/tb_bcd_timer_core.sv
// tb_bcd_timer_core: directed and random checks against an arithmetic MM:SS model
module tb_bcd_timer_core;
  localparam int DIV = 4, MAXV = 5999, PRE = 300;
  logic clk = 0, reset = 1, start = 0, stop = 0, clear = 0, lap = 0;
  logic edit_next = 0, edit_inc = 0, edit_dec = 0, mode_down = 0;
  logic [15:0] digits, lap_digits;
  logic lap_valid, running, expired, wrap;
  logic [2:0] edit_sel;
  int checks = 0, failures = 0;
  int mst = 0, mval = 0, mlap = 0, msel = 0, mph = 0;
  bit mq = 0, m_lapv = 0, m_exp = 0, m_wrap = 0;

  bcd_timer_core #(.CLK_HZ(4), .TICK_HZ(1), .N_DIGITS(4), .PRESET(16'h0500)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear), .lap(lap),
    .edit_next(edit_next), .edit_inc(edit_inc), .edit_dec(edit_dec), .mode_down(mode_down),
    .digits(digits), .lap_digits(lap_digits), .lap_valid(lap_valid), .edit_sel(edit_sel),
    .running(running), .expired(expired), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    int mm = v / 60;
    int ss = v % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // value-level model: mst 0=idle 1=run 2=pause 3=expired, mval in seconds
  task automatic model();
    bit tk, ip;
    int d[4];
    int r[4] = '{10, 6, 10, 10};
    m_lapv = 0; m_exp = 0; m_wrap = 0;
    if (reset) begin
      mst = 0; mval = 0; mlap = 0; msel = 0; mph = 0; mq = 0;
      return;
    end
    tk = mph == DIV - 1;
    mph = tk ? 0 : mph + 1;
    ip = mst == 0 || mst == 2;
    if (clear || (mst != 1 && mode_down != mq)) begin
      mst = 0; mval = mode_down ? PRE : 0; msel = 0; mq = mode_down;
    end else if (mst == 1) begin
      if (lap && !stop) begin mlap = mval; m_lapv = 1; end
      if (stop) mst = 2;
      if (tk) begin
        if (!mq) begin
          if (mval == MAXV) begin mval = 0; m_wrap = 1; end
          else mval++;
        end else begin
          mval--;
          if (mval == 0) begin mst = 3; m_exp = 1; end
        end
      end
    end else if (ip && start) begin
      if (!(mq && mval == 0)) begin mst = 1; mph = 0; end
    end else if (ip && !stop) begin
      if (edit_inc != edit_dec) begin
        d[0] = mval % 10; d[1] = (mval % 60) / 10; d[2] = (mval / 60) % 10; d[3] = mval / 600;
        d[msel] = edit_inc ? (d[msel] + 1) % r[msel] : (d[msel] + r[msel] - 1) % r[msel];
        mval = (d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0];
      end
      if (edit_next) msel = (msel + 1) % 4;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    chk("digits", digits, to_bcd(mval));
    chk("lap_digits", lap_digits, to_bcd(mlap));
    chk("lap_valid", lap_valid, m_lapv);
    chk("edit_sel", edit_sel, msel);
    chk("running", running, mst == 1);
    chk("expired", expired, m_exp);
    chk("wrap", wrap, m_wrap);
    start = 0; stop = 0; clear = 0; lap = 0; edit_next = 0; edit_inc = 0; edit_dec = 0;
  endtask

  initial begin
    step(); step();
    chk("rst_digits", digits, 16'h0000);
    chk("rst_running", running, 1'b0);
    reset = 0; step();
    start = 1; step(); repeat (4) step();
    chk("up_first_tick", digits, 16'h0001);
    repeat (236) step();
    chk("up_60_ticks", digits, 16'h0100);
    clear = 1; step();
    edit_dec = 1; step(); edit_next = 1; step();
    edit_dec = 1; step(); edit_next = 1; step();
    edit_dec = 1; step(); edit_next = 1; step();
    edit_dec = 1; step();
    chk("edit_max", digits, 16'h9959);
    start = 1; step(); repeat (4) step();
    chk("wrap_digits", digits, 16'h0000);
    chk("wrap_pulse", wrap, 1'b1);
    chk("wrap_running", running, 1'b1);
    step();
    chk("wrap_once", wrap, 1'b0);
    mode_down = 1; step();
    chk("mode_in_run", running, 1'b1);
    stop = 1; step(); step();
    clear = 1; step();
    chk("down_preset", digits, 16'h0500);
    start = 1; step(); repeat (1199) step();
    chk("down_last", digits, 16'h0001);
    step();
    chk("down_zero", digits, 16'h0000);
    chk("down_expired", expired, 1'b1);
    step();
    chk("expired_once", expired, 1'b0);
    start = 1; step();
    chk("exp_start_ign", running, 1'b0);
    mode_down = 0; step();
    edit_next = 1; step(); edit_next = 1; step();
    edit_dec = 1; step();
    chk("edit_d2", digits, 16'h0900);
    edit_next = 1; step(); edit_next = 1; step();
    start = 1; step(); repeat (8) step();
    chk("run_0902", digits, 16'h0902);
    stop = 1; step();
    edit_next = 1; step(); edit_next = 1; step();
    edit_inc = 1; step();
    chk("pause_edit_nocarry", digits, 16'h0002);
    chk("pause_kept", running, 1'b0);
    start = 1; step(); repeat (4) step();
    chk("resume", digits, 16'h0003);
    repeat (3) step();
    lap = 1; step();
    chk("lap_pre_tick", lap_digits, 16'h0003);
    chk("lap_tick", digits, 16'h0004);
    chk("lap_valid_hi", lap_valid, 1'b1);
    step();
    chk("lap_valid_lo", lap_valid, 1'b0);
    clear = 1; stop = 1; step();
    chk("clear_wins", digits, 16'h0000);
    start = 1; step(); repeat (6) step();
    reset = 1; step();
    chk("rst_mid_digits", digits, 16'h0000);
    chk("rst_mid_running", running, 1'b0);
    reset = 0;
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 599) == 0;
      clear = $urandom_range(0, 99) == 0;
      start = $urandom_range(0, 19) == 0;
      stop = $urandom_range(0, 39) == 0;
      lap = $urandom_range(0, 14) == 0;
      edit_next = $urandom_range(0, 9) == 0;
      edit_inc = $urandom_range(0, 7) == 0;
      edit_dec = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 299) == 0) mode_down = ~mode_down;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bcd_timer_core.md
BCD_TIMER_CORE -- requirements
Module: bcd_timer_core

Interface
REQ-001 Parameter CLK_HZ, default 125_000_000, input clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1, count rate; CLK_HZ/TICK_HZ SHALL be an integer of at least 2.
REQ-003 Parameter N_DIGITS, default 4, BCD digit count, legal range 4..8.
REQ-004 Parameter PRESET, default 16'h0500, BCD value loaded on clear in down mode, 4*N_DIGITS bits, zero-extended.
REQ-005 Port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Ports start, stop, clear, lap, edit_next, edit_inc, edit_dec: input, 1 each, single-cycle command pulses, already debounced upstream.
REQ-008 Port mode_down, input, 1, level: 1 = count down, 0 = count up.
REQ-009 Port digits, output, 4*N_DIGITS, current value; digit i occupies bits [4i+3:4i].
REQ-010 Port lap_digits, output, 4*N_DIGITS, captured lap value.
REQ-011 Port lap_valid, output, 1, one-cycle pulse when lap_digits updates.
REQ-012 Port edit_sel, output, 3, index of the digit selected for editing.
REQ-013 Ports running, expired, wrap: output, 1 each; running is a level, expired and wrap are one-cycle pulses.

Function
REQ-014 Digit radix: the top digit is 10; below it, even-index digits are radix 10 and odd-index digits are radix 6. For N_DIGITS = 4 the format is MM:SS; for 6 it is HH:MM:SS with a maximum of 99:59:59.
REQ-015 FSM states: IDLE, RUN, PAUSE, EXPIRED; running = (state == RUN).
REQ-016 The prescaler counts 0..CLK_HZ/TICK_HZ-1 and emits a one-cycle tick on the terminal count. It restarts at 0 on the cycle start is accepted, so the first tick arrives exactly one full period after start.
REQ-017 Transitions:
- IDLE or PAUSE + start -> RUN
- RUN + stop -> PAUSE
- any state + clear -> IDLE
- EXPIRED ignores start and stop.
REQ-018 Command priority within one cycle: clear > start/stop > lap > edit.
REQ-019 Each tick in RUN updates the whole value by +1 (up) or -1 (down) with a full-carry ripple, so all digits change on the same edge.
REQ-020 Up mode at the all-maximum value: the next tick wraps to 0, pulses wrap for one cycle, and the state stays RUN.
REQ-021 Down mode: the tick that reaches 0 moves the state to EXPIRED, pulses expired for one cycle, and digits hold 0.
REQ-022 Down mode: start with a value of 0 is ignored and the state stays put.
REQ-023 Clear sets digits to 0 in up mode and to PRESET in down mode; it also sets edit_sel to 0.
REQ-024 mode_down is sampled every cycle. A change while in RUN is ignored until the state leaves RUN. A change in any other state forces IDLE and loads the clear value for the new mode.
REQ-025 Edit commands act only in IDLE or PAUSE:
- edit_next: edit_sel increments, wrapping N_DIGITS-1 -> 0.
- edit_inc / edit_dec: the selected digit changes modulo its radix.
- If edit_inc and edit_dec arrive in the same cycle, neither acts.
REQ-026 Editing in PAUSE keeps PAUSE, so a later start resumes from the edited value.
REQ-027 lap in RUN loads lap_digits with the pre-tick value of that cycle, and lap_valid pulses on the following cycle. lap in any other state is ignored.
REQ-028 stop coincident with a tick: the tick is applied first, then the state becomes PAUSE.
REQ-029 Latency: every output is registered; a command sampled at edge k is visible after edge k.

Reset
REQ-030 While reset is high, on each clk edge:
- state = IDLE
- digits = 0, lap_digits = 0, edit_sel = 0
- prescaler = 0
- all pulse outputs = 0
REQ-031 Reset mid-count SHALL abort the count with no expired or wrap pulse.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the digit-radix function and the BCD digit width constant.
REQ-033 The prescaler SHALL be a sub-module named tick_gen (parameters CLK_HZ and TICK_HZ; ports clk, reset, restart, tick).

Verification
REQ-034 Up count, N_DIGITS = 4, CLK_HZ/TICK_HZ = 4, start: digits reads 0x0001 four cycles after start, and 0x0100 after 60 ticks.
REQ-035 Up wrap, edit the value to 0x9959, start: after one tick, digits = 0x0000, wrap pulses once, running stays 1.
REQ-036 Down mode: clear gives digits = PRESET (0x0500); after start and 300 ticks, digits = 0, expired pulses once, state is EXPIRED, and a further start is ignored.
REQ-037 PAUSE edit: stop, edit_next twice, edit_inc on digit 2 at 9, then start: digit 2 wraps to 0 with no carry into digit 3, and counting resumes from the edited value.
REQ-038 Corner cycles:
- lap and tick in the same cycle: lap_digits holds the pre-tick value, lap_valid pulses one cycle later.
- clear with stop in the same cycle: clear wins.
- reset asserted mid-run: all outputs are 0 on the next edge.
